// File: rtl/output_port_allocator_pkg.sv
// Shared router parameters, flit labels and allocator state types.
// Imported by the output port allocator and its round-robin arbiter.
package output_port_allocator_pkg;

  localparam int PORT_NUM     = 5;
  localparam int VC_NUM       = 2;
  localparam int VC_DEPTH     = 4;
  localparam int PORT_SIZE    = $clog2(PORT_NUM);
  localparam int VC_SIZE      = $clog2(VC_NUM);
  localparam int CREDIT_WIDTH = $clog2(VC_DEPTH + 1);

  typedef enum logic [1:0] {
    HEAD,
    BODY,
    TAIL,
    HEADTAIL
  } flit_label_t;

  typedef enum logic {
    IDLE,
    LOCKED
  } alloc_state_t;

  function automatic logic is_head(
    input flit_label_t l
  );
    return (l == HEAD) || (l == HEADTAIL);
  endfunction

  function automatic logic [PORT_SIZE-1:0] next_port(
    input logic [PORT_SIZE-1:0] p
  );
    if (p == PORT_SIZE'(PORT_NUM - 1))
      return '0;
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/output_port_allocator_rr_arbiter.sv
// Combinational N-way round-robin pick starting at ptr_i.
// Returns a one-hot grant, the winner index and a valid flag.
module rr_arbiter
  import output_port_allocator_pkg::*;
#(
  parameter int N = PORT_NUM,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  logic [W-1:0] w_k;

  // scan ptr, ptr+1, ... and take the first requester
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    w_k     = '0;
    for (int i = 0; i < N; i++) begin
      w_k = W'((int'(ptr_i) + i) % N);
      if (!valid_o && req_i[w_k]) begin
        valid_o      = 1'b1;
        grant_o[w_k] = 1'b1;
        idx_o        = w_k;
      end
    end
  end

endmodule

// File: rtl/output_port_allocator.sv
// Per-output switch allocator: round-robin head arbitration,
// wormhole lock for a whole packet, per-VC downstream credits.
module output_port_allocator
  import output_port_allocator_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PORT_NUM-1:0]              req_i,
  input  flit_label_t [PORT_NUM-1:0]       req_label_i,
  input  logic [PORT_NUM-1:0][VC_SIZE-1:0] req_vc_i,
  input  logic                             credit_valid_i,
  input  logic [VC_SIZE-1:0]               credit_vc_i,
  output logic [PORT_NUM-1:0]              grant_o,
  output logic                             out_valid_o,
  output logic [VC_SIZE-1:0]               out_vc_o,
  output logic                             locked_o,
  output logic [PORT_SIZE-1:0]             owner_o,
  output logic                             err_o
);

  alloc_state_t                r_state;
  logic [PORT_SIZE-1:0]        r_rr_ptr;
  logic [PORT_SIZE-1:0]        r_owner;
  logic [VC_SIZE-1:0]          r_lock_vc;
  logic [CREDIT_WIDTH-1:0]     r_credit [VC_NUM];
  logic                        r_err;

  logic [PORT_NUM-1:0]         w_elig;
  logic [PORT_NUM-1:0]         w_arb_grant;
  logic [PORT_SIZE-1:0]        w_arb_idx;
  logic                        w_arb_valid;
  logic [PORT_NUM-1:0]         w_grant;
  logic [VC_SIZE-1:0]          w_vc;
  logic                        w_fire;
  logic                        w_head_err;
  flit_label_t                 w_own_lbl;
  logic [VC_NUM-1:0]           w_dec;
  logic [VC_NUM-1:0]           w_inc;
  logic                        w_ovf;

  // a head is eligible only if its target VC has room downstream
  always_comb begin
    w_elig = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      w_elig[p] = req_i[p]
                && is_head(req_label_i[p])
                && (r_credit[req_vc_i[p]] != '0);
    end
  end

  rr_arbiter #(
    .N (PORT_NUM),
    .W (PORT_SIZE)
  ) u_rr (
    .req_i   (w_elig),
    .ptr_i   (r_rr_ptr),
    .grant_o (w_arb_grant),
    .idx_o   (w_arb_idx),
    .valid_o (w_arb_valid)
  );

  // zero-cycle grant: arbiter when idle, owner only when locked
  always_comb begin
    w_grant    = '0;
    w_vc       = '0;
    w_head_err = 1'b0;
    w_own_lbl  = req_label_i[r_owner];
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          w_grant = w_arb_grant;
          if (w_arb_valid)
            w_vc = req_vc_i[w_arb_idx];
        end
        LOCKED: begin
          w_vc = r_lock_vc;
          if (req_i[r_owner]) begin
            if (is_head(w_own_lbl))
              w_head_err = 1'b1;
            else if (r_credit[r_lock_vc] != '0)
              w_grant[r_owner] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_fire = |w_grant;

  // per-VC credit consume/return strobes and overflow detect
  always_comb begin
    w_dec = '0;
    w_inc = '0;
    w_ovf = 1'b0;
    for (int v = 0; v < VC_NUM; v++) begin
      w_dec[v] = w_fire && (w_vc == VC_SIZE'(v));
      w_inc[v] = credit_valid_i && (credit_vc_i == VC_SIZE'(v));
      if (w_inc[v] && !w_dec[v]
          && r_credit[v] == CREDIT_WIDTH'(VC_DEPTH))
        w_ovf = 1'b1;
    end
  end

  // allocation state machine: lock on HEAD, release on TAIL
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_owner   <= '0;
      r_lock_vc <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_arb_valid) begin
            r_owner <= w_arb_idx;
            if (req_label_i[w_arb_idx] == HEAD) begin
              r_state   <= LOCKED;
              r_lock_vc <= req_vc_i[w_arb_idx];
            end else begin
              r_rr_ptr <= next_port(w_arb_idx);
            end
          end
        end
        LOCKED: begin
          if (w_fire && w_own_lbl == TAIL) begin
            r_state  <= IDLE;
            r_rr_ptr <= next_port(r_owner);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // credit counters saturate at depth; sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++)
        r_credit[v] <= CREDIT_WIDTH'(VC_DEPTH);
      r_err <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (w_dec[v] && !w_inc[v])
          r_credit[v] <= r_credit[v] - 1'b1;
        else if (w_inc[v] && !w_dec[v]
                 && r_credit[v] != CREDIT_WIDTH'(VC_DEPTH))
          r_credit[v] <= r_credit[v] + 1'b1;
      end
      r_err <= r_err | w_head_err | w_ovf;
    end
  end

  assign grant_o     = w_grant;
  assign out_valid_o = w_fire;
  assign out_vc_o    = w_vc;
  assign locked_o    = !rst && (r_state == LOCKED);
  assign owner_o     = rst ? '0 : r_owner;
  assign err_o       = !rst && r_err;

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed and random checks of output_port_allocator against
// a transaction-level reference model of allocation and credits.
module tb_output_port_allocator;
  import output_port_allocator_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [4:0]            req;
  flit_label_t [4:0]     lab;
  logic [4:0][0:0]       vc;
  logic                  cv;
  logic [0:0]            cvc;
  logic [4:0]            grant_o;
  logic                  out_valid_o;
  logic [0:0]            out_vc_o;
  logic                  locked_o;
  logic [2:0]            owner_o;
  logic                  err_o;

  int compared = 0;
  int mismatched = 0;

  // reference model: packet ownership, scan start, credits
  bit m_locked;
  int m_owner, m_lockvc, m_ptr;
  int m_cred [2];
  bit m_err;

  logic [4:0] e_grant;
  bit         e_valid;
  int         e_vc;
  int         e_win;
  bit         e_herr;

  always #5 clk = ~clk;

  output_port_allocator dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req),
    .req_label_i    (lab),
    .req_vc_i       (vc),
    .credit_valid_i (cv),
    .credit_vc_i    (cvc),
    .grant_o        (grant_o),
    .out_valid_o    (out_valid_o),
    .out_vc_o       (out_vc_o),
    .locked_o       (locked_o),
    .owner_o        (owner_o),
    .err_o          (err_o)
  );

  function automatic bit hd(flit_label_t l);
    return l == HEAD || l == HEADTAIL;
  endfunction

  task model_comb();
    e_grant = '0; e_valid = 0; e_vc = 0;
    e_win = -1; e_herr = 0;
    if (rst) return;
    if (!m_locked) begin
      for (int i = 0; i < 5; i++) begin
        int p;
        p = (m_ptr + i) % 5;
        if (e_win < 0 && req[p] && hd(lab[p])
            && m_cred[int'(vc[p])] > 0)
          e_win = p;
      end
      if (e_win >= 0) begin
        e_grant[e_win] = 1'b1;
        e_vc = int'(vc[e_win]);
      end
    end else begin
      e_vc = m_lockvc;
      if (req[m_owner]) begin
        if (hd(lab[m_owner])) e_herr = 1;
        else if (m_cred[m_lockvc] > 0)
          e_grant[m_owner] = 1'b1;
      end
    end
    e_valid = (e_grant != 0);
  endtask

  task model_seq();
    if (rst) begin
      m_locked = 0; m_owner = 0; m_lockvc = 0;
      m_ptr = 0; m_err = 0;
      m_cred[0] = 4; m_cred[1] = 4;
      return;
    end
    if (!m_locked) begin
      if (e_valid) begin
        m_owner = e_win;
        if (lab[e_win] == HEAD) begin
          m_locked = 1;
          m_lockvc = int'(vc[e_win]);
        end else begin
          m_ptr = (e_win + 1) % 5;
        end
      end
    end else begin
      if (e_herr) m_err = 1;
      if (e_valid && lab[m_owner] == TAIL) begin
        m_locked = 0;
        m_ptr = (m_owner + 1) % 5;
      end
    end
    for (int v = 0; v < 2; v++) begin
      bit d, u;
      d = e_valid && e_vc == v;
      u = cv && int'(cvc) == v;
      if (d && !u) m_cred[v]--;
      else if (u && !d) begin
        if (m_cred[v] == 4) m_err = 1;
        else m_cred[v]++;
      end
    end
  endtask

  task check_all();
    compared++;
    assert (grant_o === e_grant) else begin
      mismatched++;
      $error("FAIL grant obs=%b exp=%b", grant_o, e_grant);
    end
    compared++;
    assert (out_valid_o === e_valid) else begin
      mismatched++;
      $error("FAIL out_valid obs=%b exp=%b", out_valid_o, e_valid);
    end
    compared++;
    assert (int'(out_vc_o) === e_vc) else begin
      mismatched++;
      $error("FAIL out_vc obs=%0d exp=%0d", out_vc_o, e_vc);
    end
    compared++;
    assert (locked_o === (!rst && m_locked)) else begin
      mismatched++;
      $error("FAIL locked obs=%b exp=%b", locked_o, !rst && m_locked);
    end
    compared++;
    assert (int'(owner_o) === (rst ? 0 : m_owner)) else begin
      mismatched++;
      $error("FAIL owner obs=%0d exp=%0d", owner_o, rst ? 0 : m_owner);
    end
    compared++;
    assert (err_o === (!rst && m_err)) else begin
      mismatched++;
      $error("FAIL err obs=%b exp=%b", err_o, !rst && m_err);
    end
  endtask

  // one cycle: settle, check vs model (and optional constant), clock
  task cyc(input logic [4:0] eg, input bit chk);
    #1;
    model_comb();
    check_all();
    if (chk) begin
      compared++;
      assert (grant_o === eg) else begin
        mismatched++;
        $error("FAIL directed_grant obs=%b exp=%b", grant_o, eg);
      end
    end
    model_seq();
    @(posedge clk);
    @(negedge clk);
  endtask

  task drv(input int p, input flit_label_t l, input int v);
    req[p] = 1'b1; lab[p] = l; vc[p] = 1'(v);
  endtask

  task clr();
    req = '0; cv = 0; cvc = '0;
  endtask

  task ret(input int v, input int n);
    cv = 1; cvc = 1'(v);
    for (int i = 0; i < n; i++) cyc(5'b0, 1);
    cv = 0;
  endtask

  task chk_bit(input string tag, input logic o, input logic e);
    #1;
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s obs=%b exp=%b", tag, o, e);
    end
  endtask

  initial begin
    rst = 1; req = '0; cv = 0; cvc = '0;
    for (int p = 0; p < 5; p++) begin
      lab[p] = HEAD; vc[p] = '0;
    end
    @(negedge clk);
    cyc(5'b0, 1);
    cyc(5'b0, 1);
    rst = 0;

    // alternating single-flit packets drain VC0 credits
    drv(1, HEADTAIL, 0); drv(3, HEADTAIL, 0);
    cyc(5'b00010, 1); cyc(5'b01000, 1);
    cyc(5'b00010, 1); cyc(5'b01000, 1);
    cyc(5'b0, 1); cyc(5'b0, 1);
    cv = 1; cvc = 0; cyc(5'b0, 1);
    cv = 0; cyc(5'b00010, 1);
    clr(); ret(0, 4);

    // wormhole packet from 2 while 0 waits with a head
    drv(2, HEAD, 1); drv(0, HEAD, 0);
    cyc(5'b00100, 1);
    lab[2] = BODY; cyc(5'b00100, 1);
    chk_bit("locked_mid", locked_o, 1'b1);
    cyc(5'b00100, 1);
    lab[2] = TAIL; cyc(5'b00100, 1);
    req[2] = 0; cyc(5'b00001, 1);
    lab[0] = TAIL; cyc(5'b00001, 1);
    clr(); ret(1, 4); ret(0, 2);

    // wrap-around from pointer 4 to 0
    drv(3, HEADTAIL, 0); cyc(5'b01000, 1);
    clr();
    drv(4, HEADTAIL, 0); drv(0, HEADTAIL, 0);
    cyc(5'b10000, 1); cyc(5'b00001, 1);
    clr(); ret(0, 3);

    // empty VC1 blocks a head while VC0 head proceeds
    drv(2, HEADTAIL, 1);
    for (int i = 0; i < 4; i++) cyc(5'b00100, 1);
    clr();
    drv(0, HEAD, 1); drv(1, HEAD, 0);
    cyc(5'b00010, 1);
    lab[1] = TAIL; cyc(5'b00010, 1);
    req[1] = 0; cyc(5'b0, 1);
    clr(); ret(1, 1);
    drv(0, HEADTAIL, 1); cv = 1; cvc = 1;
    cyc(5'b00001, 1);
    cv = 0; cyc(5'b00001, 1);
    cyc(5'b0, 1);
    clr(); ret(1, 4); ret(0, 2);
    chk_bit("err_clean", err_o, 1'b0);

    // credit overflow sets sticky error
    ret(0, 1);
    chk_bit("err_ovf", err_o, 1'b1);
    rst = 1; cyc(5'b0, 1); rst = 0;

    // owner re-presenting a head while locked
    drv(2, HEAD, 0); cyc(5'b00100, 1);
    cyc(5'b0, 1);
    chk_bit("err_head", err_o, 1'b1);

    // reset mid-packet drops the lock
    lab[2] = BODY; cyc(5'b00100, 1);
    rst = 1; cyc(5'b0, 1); rst = 0;
    clr();
    chk_bit("unlocked", locked_o, 1'b0);
    drv(0, HEAD, 0); cyc(5'b00001, 1);
    clr();

    // random traffic against the model
    rst = 1; cyc(5'b0, 1); rst = 0;
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 5; p++) begin
        req[p] = 1'($urandom_range(0, 1));
        lab[p] = flit_label_t'($urandom_range(0, 3));
        vc[p]  = 1'($urandom_range(0, 1));
      end
      cv  = ($urandom_range(0, 3) == 0);
      cvc = 1'($urandom_range(0, 1));
      if (n % 100 == 99) rst = 1;
      cyc(5'b0, 0);
      rst = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
